// File: rtl/binary_to_bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter: one shift/add-3 step per clock,
// valid/ready handshakes on both sides, sticky overflow and leading-zero blanking flags.
module binary_to_bcd_seq #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow,
    output logic [DIGITS-1:0]     blank
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned BcdW = 4 * DIGITS;

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  bin_q, bin_d;
    logic [BcdW-1:0]   dig_q, dig_d;
    logic              ovf_q, ovf_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [BcdW-1:0]   bcd_q, bcd_d;
    logic              overflow_q, overflow_d;

    logic [BcdW-1:0]   adj;
    logic [BcdW-1:0]   shifted;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            bin_q      <= '0;
            dig_q      <= '0;
            ovf_q      <= 1'b0;
            cnt_q      <= '0;
            bcd_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            dig_q      <= dig_d;
            ovf_q      <= ovf_d;
            cnt_q      <= cnt_d;
            bcd_q      <= bcd_d;
            overflow_q <= overflow_d;
        end
    end

    // Per-digit add-3 correction, no carry between digits.
    always_comb begin
        adj = dig_q;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (dig_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = dig_q[4*i +: 4] + 4'd3;
            end
        end
        shifted = {adj[BcdW-2:0], bin_q[WIDTH-1]};
    end

    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        dig_d      = dig_q;
        ovf_d      = ovf_q;
        cnt_d      = cnt_q;
        bcd_d      = bcd_q;
        overflow_d = overflow_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    bin_d   = in_data;
                    dig_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                bin_d = bin_q << 1;
                dig_d = shifted;
                // A set top-digit MSB after correction is a lost carry of 10^DIGITS.
                ovf_d = ovf_q | adj[BcdW-1];
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    state_d    = StDone;
                    bcd_d      = shifted;
                    overflow_d = ovf_q | adj[BcdW-1];
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Leading-zero flags derive from the registered result, so they track bcd exactly.
    always_comb begin
        logic all_zero;
        blank    = '0;
        all_zero = 1'b1;
        for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
            all_zero = all_zero & (bcd_q[4*i +: 4] == 4'd0);
            blank[i] = all_zero;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign bcd       = bcd_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_binary_to_bcd_seq.sv
// Bench for binary_to_bcd_seq: three instances (W8/D3, W10/D3, W16/D5) checked against a
// decimal-arithmetic reference model, with directed vectors, exhaustive, random and corner cases.
module tb_binary_to_bcd_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] din;
    logic [2:0]  iv, ordy, ir, ov, of;
    logic [11:0] bcd0, bcd1;
    logic [19:0] bcd2;
    logic [2:0]  bl0, bl1;
    logic [4:0]  bl2;
    logic [19:0] bcd_w [3];
    logic [4:0]  bl_w  [3];

    int total = 0;
    int bad   = 0;
    int wid [3] = '{8, 10, 16};
    int ndig [3] = '{3, 3, 5};

    always #5 clk = ~clk;

    binary_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) u_w8 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(din[7:0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .bcd(bcd0), .overflow(of[0]), .blank(bl0)
    );
    binary_to_bcd_seq #(.WIDTH(10), .DIGITS(3)) u_w10 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(din[9:0]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .bcd(bcd1), .overflow(of[1]), .blank(bl1)
    );
    binary_to_bcd_seq #(.WIDTH(16), .DIGITS(5)) u_w16 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(din[15:0]),
        .out_valid(ov[2]), .out_ready(ordy[2]), .bcd(bcd2), .overflow(of[2]), .blank(bl2)
    );

    assign bcd_w[0] = {8'h0, bcd0};
    assign bcd_w[1] = {8'h0, bcd1};
    assign bcd_w[2] = bcd2;
    assign bl_w[0]  = {2'b0, bl0};
    assign bl_w[1]  = {2'b0, bl1};
    assign bl_w[2]  = bl2;

    typedef struct {
        int          sel;
        logic [31:0] v;
        logic [19:0] b;
        logic        o;
        logic [4:0]  bl;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Decimal reference: value mod 10^n split into digits by division.
    function automatic void model(input int sel, input longint v, output logic [19:0] b,
                                  output logic o, output logic [4:0] bl);
        longint m = 1;
        longint r;
        logic   z = 1'b1;
        for (int i = 0; i < ndig[sel]; i++) m = m * 10;
        o = (v >= m);
        r = v % m;
        b = '0;
        for (int i = 0; i < ndig[sel]; i++) begin
            b[4*i +: 4] = 4'(r % 10);
            r = r / 10;
        end
        bl = '0;
        for (int i = ndig[sel] - 1; i >= 1; i--) begin
            z = z && (b[4*i +: 4] == 4'd0);
            bl[i] = z;
        end
    endfunction

    task automatic conv(input int s, input logic [31:0] v, output logic [19:0] b,
                        output logic o, output logic [4:0] bl, output int lat);
        int n = 0;
        while (!ir[s] && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("in_ready_idle", 32'(ir[s]), 32'd1);
        din   = v;
        iv[s] = 1'b1;
        @(posedge clk); #1;
        iv[s] = 1'b0;
        lat = 0;
        while (!ov[s] && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        b  = bcd_w[s];
        o  = of[s];
        bl = bl_w[s];
        ordy[s] = 1'b1;
        @(posedge clk); #1;
        ordy[s] = 1'b0;
    endtask

    task automatic run_check(input string tag, input int s, input logic [31:0] v);
        logic [19:0] b, eb;
        logic        o, eo;
        logic [4:0]  bl, ebl;
        int          lat;
        model(s, longint'(v), eb, eo, ebl);
        conv(s, v, b, o, bl, lat);
        if (b !== eb || o !== eo || bl !== ebl || lat != wid[s]) begin
            $display("%s v=%0d", tag, v);
        end
        chk({tag, "_bcd"}, 32'(b), 32'(eb));
        chk({tag, "_ovf"}, 32'(o), 32'(eo));
        chk({tag, "_blank"}, 32'(bl), 32'(ebl));
        chk({tag, "_lat"}, 32'(lat), 32'(wid[s]));
    endtask

    initial begin
        vec_t        vt [11];
        logic [19:0] b, held;
        logic        o;
        logic [4:0]  bl;
        int          lat, n;
        logic        saw;

        vt[0]  = '{0, 255,   20'h00255, 1'b0, 5'b00000};
        vt[1]  = '{0, 0,     20'h00000, 1'b0, 5'b00110};
        vt[2]  = '{0, 9,     20'h00009, 1'b0, 5'b00110};
        vt[3]  = '{0, 40,    20'h00040, 1'b0, 5'b00100};
        vt[4]  = '{1, 1023,  20'h00023, 1'b1, 5'b00100};
        vt[5]  = '{1, 999,   20'h00999, 1'b0, 5'b00000};
        vt[6]  = '{1, 1000,  20'h00000, 1'b1, 5'b00110};
        vt[7]  = '{2, 65535, 20'h65535, 1'b0, 5'b00000};
        vt[8]  = '{2, 0,     20'h00000, 1'b0, 5'b11110};
        vt[9]  = '{2, 100,   20'h00100, 1'b0, 5'b11000};
        vt[10] = '{0, 128,   20'h00128, 1'b0, 5'b00000};

        rst = 1'b1; iv = '0; ordy = '0; din = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(ir), 32'h7);
        chk("rst_out_valid", 32'(ov), 32'h0);
        chk("rst_bcd", 32'(bcd0), 32'h0);
        chk("rst_ovf", 32'(of), 32'h0);
        chk("rst_blank8", 32'(bl0), 32'b110);
        chk("rst_blank16", 32'(bl2), 32'b11110);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            conv(vt[i].sel, vt[i].v, b, o, bl, lat);
            chk($sformatf("vec%0d_bcd", i), 32'(b), 32'(vt[i].b));
            chk($sformatf("vec%0d_ovf", i), 32'(o), 32'(vt[i].o));
            chk($sformatf("vec%0d_blank", i), 32'(bl), 32'(vt[i].bl));
            chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(wid[vt[i].sel]));
        end

        // Backpressure with in_valid noise during SHIFT.
        din = 32'd200; iv[0] = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        @(posedge clk); #1;
        din = 32'd77; iv[0] = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        n = 0;
        while (!ov[0] && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("bp_valid", 32'(ov[0]), 32'd1);
        chk("bp_bcd", 32'(bcd0), 32'h200);
        held = bcd_w[0];
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_hold_valid", 32'(ov[0]), 32'd1);
            chk("bp_hold_bcd", 32'(bcd_w[0]), 32'(held));
            chk("bp_hold_in_ready", 32'(ir[0]), 32'd0);
        end
        ordy[0] = 1'b1;
        @(posedge clk); #1;
        ordy[0] = 1'b0;
        chk("bp_release_in_ready", 32'(ir[0]), 32'd1);
        chk("bp_release_valid", 32'(ov[0]), 32'd0);
        chk("bp_bcd_after", 32'(bcd0), 32'h200);

        // Reset on the 4th SHIFT cycle aborts the conversion.
        din = 32'd77; iv[0] = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_in_ready", 32'(ir[0]), 32'd1);
        chk("abort_bcd", 32'(bcd0), 32'h0);
        chk("abort_ovf", 32'(of[0]), 32'd0);
        chk("abort_blank", 32'(bl0), 32'b110);
        saw = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (ov[0]) saw = 1'b1;
            @(posedge clk); #1;
        end
        chk("abort_no_valid", 32'(saw), 32'd0);
        run_check("after_abort", 0, 32'd128);

        for (int v = 0; v < 256; v++) run_check("exh8", 0, 32'(v));
        for (int i = 0; i < 300; i++) run_check("rnd10", 1, 32'($urandom_range(0, 1023)));
        for (int i = 0; i < 2000; i++) run_check("rnd16", 2, 32'($urandom_range(0, 65535)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
